// File: rtl/gfsk_pkg.sv
// gfsk_pkg: shared definitions for the GFSK pulse shaper.
//   - OSR/SPAN/OUT_W defaults
//   - FSM state enum {IDLE, RUN, DRAIN}
//   - 2-bit signed symbol type and its three legal values
//   - Q1.8 Gaussian (BT=0.5) pulse table H[0:OSR*SPAN-1]
//   - saturating clamp of the accumulator to [-255,+255]
// The optional PRBS source is enabled by the macro GFSK_PRBS_SRC_EN
// (see gfsk_pulse_shaper.sv).
package gfsk_pkg;

    localparam int OSR_DEF   = 8;
    localparam int SPAN_DEF  = 3;
    localparam int OUT_W_DEF = 9;
    localparam int ACC_W_DEF = OUT_W_DEF + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic signed [1:0] sym_t;

    localparam sym_t SYM_ZERO = 2'sb00;
    localparam sym_t SYM_POS  = 2'sb01;
    localparam sym_t SYM_NEG  = 2'sb11;

    // Symmetric pulse, H[i] == H[23-i]. For each phase p the three taps
    // H[p]+H[p+8]+H[p+16] sum to 254 or 255, so a constant symbol stream
    // stays inside the Q1.8 range without clipping.
    localparam logic signed [OUT_W_DEF-1:0] H [0:OSR_DEF*SPAN_DEF-1] = '{
        9'sd2,   9'sd5,   9'sd10,  9'sd18,  9'sd31,  9'sd50,  9'sd76,  9'sd108,
        9'sd145, 9'sd173, 9'sd194, 9'sd206, 9'sd206, 9'sd194, 9'sd173, 9'sd145,
        9'sd108, 9'sd76,  9'sd50,  9'sd31,  9'sd18,  9'sd10,  9'sd5,   9'sd2
    };

    // Saturate so the output is symmetric: -256 is never produced.
    function automatic logic signed [OUT_W_DEF-1:0] clamp_q18(
        input logic signed [ACC_W_DEF-1:0] acc
    );
        logic signed [OUT_W_DEF-1:0] res;
        if (acc > 11'sd255) begin
            res = 9'sd255;
        end else if (acc < -11'sd255) begin
            res = -9'sd255;
        end else begin
            res = acc[OUT_W_DEF-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/gfsk_prbs9.sv
// gfsk_prbs9: PRBS9 generator, polynomial x^9+x^5+1, seed 9'h1FF.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (reloads the seed)
//   step  in  advance the sequence by one bit
//   bit_o out current PRBS bit (MSB of the register)
// Only instantiated when GFSK_PRBS_SRC_EN is defined.
module gfsk_prbs9 (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic bit_o
);

    logic [8:0] lfsr_q;
    logic [8:0] lfsr_d;

    // Next LFSR value: shift left, feedback = tap9 ^ tap5.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR register with synchronous reset to the all-ones seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 9'h1FF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[8];

endmodule

// File: rtl/gfsk_pulse_shaper.sv
// gfsk_pulse_shaper: maps a serial TX bit stream to Gaussian-shaped,
// oversampled frequency-control samples (signed Q1.8) for the FSK modulator.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   output-sample strobe; all state advances only when en=1
//   bit_in     in   data bit (1 -> +1, 0 -> -1)
//   bit_valid  in   bit_in valid
//   prbs_sel   in   (only with GFSK_PRBS_SRC_EN) 1 = use internal PRBS9 source
//   bit_ready  out  bit taken this cycle (combinational, independent of bit_valid)
//   gf_out     out  shaped sample, saturated to [-255,+255]
//   gf_valid   out  one-cycle pulse per new gf_out
//   busy       out  state != IDLE
// Macro GFSK_PRBS_SRC_EN adds the prbs_sel port and the PRBS9 source.
module gfsk_pulse_shaper
    import gfsk_pkg::*;
#(
    parameter int OSR   = OSR_DEF,
    parameter int SPAN  = SPAN_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    bit_in,
    input  logic                    bit_valid,
`ifdef GFSK_PRBS_SRC_EN
    input  logic                    prbs_sel,
`endif
    output logic                    bit_ready,
    output logic signed [OUT_W-1:0] gf_out,
    output logic                    gf_valid,
    output logic                    busy
);

    localparam int PH_W  = $clog2(OSR);
    localparam int IDX_W = $clog2(OSR * SPAN);
    localparam int ACC_W = OUT_W + 2;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    state_e                   state_q, state_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    sym_t                     sym_q [SPAN];
    sym_t                     sym_d [SPAN];
    logic signed [OUT_W-1:0]  gf_out_q, gf_out_d;
    logic                     gf_valid_q, gf_valid_d;

    logic                     boundary_s;
    logic                     transfer_s;
    logic                     src_valid_s;
    logic                     src_bit_s;
    logic                     ready_s;
    logic                     post_zero_s;
    sym_t                     new_sym_s;
    logic [IDX_W-1:0]         idx_s;
    logic signed [ACC_W-1:0]  acc_s;

    assign boundary_s = en && (phase_q == PH_LAST);

`ifdef GFSK_PRBS_SRC_EN
    logic prbs_bit_s;

    gfsk_prbs9 u_prbs (
        .clk   (clk),
        .rst   (rst),
        .step  (boundary_s),
        .bit_o (prbs_bit_s)
    );

    // Source select: the PRBS always offers a bit and hides bit_ready.
    always_comb begin
        if (prbs_sel) begin
            src_valid_s = 1'b1;
            src_bit_s   = prbs_bit_s;
            ready_s     = 1'b0;
        end else begin
            src_valid_s = bit_valid;
            src_bit_s   = bit_in;
            ready_s     = boundary_s && !rst;
        end
    end
`else
    // Source select: external bit stream only.
    always_comb begin
        src_valid_s = bit_valid;
        src_bit_s   = bit_in;
        ready_s     = boundary_s && !rst;
    end
`endif

    assign transfer_s = boundary_s && !rst && src_valid_s;
    assign new_sym_s  = transfer_s ? (src_bit_s ? SYM_POS : SYM_NEG) : SYM_ZERO;

    // Post-shift window empty: no new symbol and every surviving slot is zero.
    always_comb begin
        post_zero_s = (new_sym_s == SYM_ZERO);
        for (int k = 0; k < SPAN - 1; k++) begin
            if (sym_q[k] != SYM_ZERO) begin
                post_zero_s = 1'b0;
            end else begin
                post_zero_s = post_zero_s;
            end
        end
    end

    // Convolution: each symbol slot k selects tap k*OSR+phase; add/sub only.
    always_comb begin
        acc_s = '0;
        idx_s = '0;
        for (int k = 0; k < SPAN; k++) begin
            idx_s = IDX_W'(k * OSR) + IDX_W'(phase_q);
            case (sym_q[k])
                SYM_POS: acc_s = acc_s + ACC_W'(H[idx_s]);
                SYM_NEG: acc_s = acc_s - ACC_W'(H[idx_s]);
                default: acc_s = acc_s;
            endcase
        end
    end

    // FSM next state; transitions happen only at a symbol boundary.
    always_comb begin
        state_d = state_q;
        if (boundary_s) begin
            case (state_q)
                IDLE:    state_d = transfer_s ? RUN : IDLE;
                RUN:     state_d = transfer_s ? RUN : DRAIN;
                DRAIN: begin
                    if (transfer_s) begin
                        state_d = RUN;
                    end else if (post_zero_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values: phase, symbol window and output sample.
    always_comb begin
        phase_d    = phase_q;
        sym_d      = sym_q;
        gf_out_d   = gf_out_q;
        gf_valid_d = 1'b0;
        if (en) begin
            gf_out_d   = clamp_q18(acc_s);
            gf_valid_d = 1'b1;
            // Entering or staying in IDLE parks the phase on the boundary
            // so the very next strobe can accept a bit.
            if (state_d == IDLE) begin
                phase_d = PH_LAST;
            end else if (phase_q == PH_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            if (boundary_s) begin
                sym_d[0] = new_sym_s;
                for (int k = 1; k < SPAN; k++) begin
                    sym_d[k] = sym_q[k-1];
                end
            end else begin
                sym_d = sym_q;
            end
        end else begin
            gf_valid_d = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_LAST;
            gf_out_q   <= '0;
            gf_valid_q <= 1'b0;
            for (int k = 0; k < SPAN; k++) begin
                sym_q[k] <= SYM_ZERO;
            end
        end else begin
            phase_q    <= phase_d;
            gf_out_q   <= gf_out_d;
            gf_valid_q <= gf_valid_d;
            for (int k = 0; k < SPAN; k++) begin
                sym_q[k] <= sym_d[k];
            end
        end
    end

    // Output decode.
    always_comb begin
        busy      = (state_q != IDLE);
        bit_ready = ready_s;
        gf_out    = gf_out_q;
        gf_valid  = gf_valid_q;
    end

endmodule

// File: tb/tb_gfsk_pulse_shaper.sv
// Self-checking bench for gfsk_pulse_shaper: directed table, hand-written
// corner sequences and a randomized run, all compared against a symbol-window
// reference model held in this file.
module tb_gfsk_pulse_shaper;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_ready;
    logic signed [8:0] gf_out;
    logic              gf_valid;
    logic              busy;
`ifdef GFSK_PRBS_SRC_EN
    logic              prbs_sel = 1'b0;
`endif

    gfsk_pulse_shaper dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
`ifdef GFSK_PRBS_SRC_EN
        .prbs_sel  (prbs_sel),
`endif
        .bit_ready (bit_ready),
        .gf_out    (gf_out),
        .gf_valid  (gf_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bench's own copy of the Gaussian pulse samples.
    int h_ref [24] = '{2, 5, 10, 18, 31, 50, 76, 108,
                       145, 173, 194, 206, 206, 194, 173, 145,
                       108, 76, 50, 31, 18, 10, 5, 2};

    int n_err = 0;
    int n_chk = 0;

    // Reference model: the last three symbols (newest first), the sample
    // phase inside the current symbol, and the predicted outputs.
    int m_hist [3];
    int m_ph;
    int m_out;
    bit m_valid;
    bit m_busy;
    bit m_prbs = 1'b0;
    int prbs_n;
    bit last_take;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PRBS9 as a bit recurrence: seed gives nine 1s, b[n] = b[n-9]^b[n-5].
    function automatic bit prbs_ref(input int n);
        bit b[$];
        for (int i = 0; i <= n; i++) begin
            if (i < 9) b.push_back(1'b1);
            else       b.push_back(b[i-9] ^ b[i-5]);
        end
        return b[n];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_hist[k] = 0;
        m_ph    = 7;
        m_out   = 0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        prbs_n  = 0;
    endtask

    // One clock: drive inputs, check bit_ready, advance model, check outputs.
    task automatic cycle(input bit r, input bit e, input bit bv, input bit bi);
        int acc;
        int sym;
        bit take;
        bit b;
        rst = r; en = e; bit_valid = bv; bit_in = bi;
        #1;
        check("bit_ready", int'(bit_ready), int'(!r && e && m_ph == 7 && !m_prbs));
        take = 1'b0;
        if (r) begin
            model_reset();
        end else if (e) begin
            acc = 0;
            for (int k = 0; k < 3; k++) acc += m_hist[k] * h_ref[k*8 + m_ph];
            m_out   = (acc > 255) ? 255 : ((acc < -255) ? -255 : acc);
            m_valid = 1'b1;
            if (m_ph == 7) begin
                b    = m_prbs ? prbs_ref(prbs_n) : bi;
                take = m_prbs ? 1'b1 : bv;
                prbs_n++;
                sym  = take ? (b ? 1 : -1) : 0;
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = sym;
                // The shaper is busy exactly while any symbol is in the window.
                m_busy = (m_hist[0] != 0) || (m_hist[1] != 0) || (m_hist[2] != 0);
            end
            m_ph = m_busy ? (m_ph + 1) % 8 : 7;
        end else begin
            m_valid = 1'b0;
        end
        last_take = take;
        @(posedge clk);
        @(negedge clk);
        check("gf_out", int'(gf_out), m_out);
        check("gf_valid", int'(gf_valid), int'(m_valid));
        check("busy", int'(busy), int'(m_busy));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit en;
        bit bv;
        bit bi;
        int exp_out;
        bit exp_valid;
        bit exp_busy;
    } vec_t;

    vec_t tbl [26];
    int   alt_q [$];

    initial begin
        bit ab;
        bit started;
        bit sb;
        bit have;

        // Single +1 symbol: one idle-phase zero sample, then the 24 taps, then 0.
        tbl[0] = '{en: 1'b1, bv: 1'b1, bi: 1'b1, exp_out: 0, exp_valid: 1'b1, exp_busy: 1'b1};
        for (int i = 0; i < 24; i++) begin
            tbl[1+i] = '{en: 1'b1, bv: 1'b0, bi: 1'b0, exp_out: h_ref[i],
                         exp_valid: 1'b1, exp_busy: (i < 23)};
        end
        tbl[25] = '{en: 1'b1, bv: 1'b0, bi: 1'b0, exp_out: 0, exp_valid: 1'b1, exp_busy: 1'b0};

        model_reset();
        @(negedge clk);

        // Reset held with en toggling.
        for (int i = 0; i < 6; i++) cycle(1'b1, i[0], 1'b1, 1'b1);

        // Directed table.
        for (int i = 0; i < 26; i++) begin
            cycle(1'b0, tbl[i].en, tbl[i].bv, tbl[i].bi);
            check("tbl_out", int'(gf_out), tbl[i].exp_out);
            check("tbl_valid", int'(gf_valid), int'(tbl[i].exp_valid));
            check("tbl_busy", int'(busy), int'(tbl[i].exp_busy));
        end

        // Continuous 1s, then continuous 0s, then drain.
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (gf_out == -9'sd256) check("never_m256", int'(gf_out), -255);
        end
        idle_cycles(30);

        // Alternating 1,0 with en one cycle in four.
        ab = 1'b1;
        started = 1'b0;
        for (int n = 0; n < 240; n++) begin
            cycle(1'b0, (n % 4) == 0, 1'b1, ab);
            if (started && gf_valid) alt_q.push_back(int'(gf_out));
            if (last_take) begin
                started = 1'b1;
                ab = ~ab;
            end
        end
        check("alt_len", int'(alt_q.size() >= 40), 1);
        if (alt_q.size() >= 40) begin
            for (int j = 16; j < 32; j++) check("alt_neg", alt_q[j], -alt_q[j+8]);
            check("alt_nonzero", int'(alt_q[19] != 0), 1);
        end
        for (int i = 0; i < 120; i++) cycle(1'b0, (i % 4) == 0, 1'b0, 1'b0);

        // One missed boundary mid-packet: a single zero symbol, no IDLE.
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, 1'b1, !(i >= 20 && i < 28), 1'b1);
            check("gap_busy", int'(busy), 1);
        end
        // Reset mid-packet returns everything to reset values at once.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out", int'(gf_out), 0);
        check("mid_rst_valid", int'(gf_valid), 0);
        idle_cycles(4);

        // Randomized traffic; the source holds its bit until accepted.
        have = 1'b0;
        sb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                have = 1'b1;
                sb = 1'($urandom_range(0, 1));
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, have, sb);
            if (last_take || rst) have = 1'b0;
        end
        idle_cycles(30);

`ifdef GFSK_PRBS_SRC_EN
        // PRBS source: ignore external inputs, symbols follow PRBS9 from reset.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        prbs_sel = 1'b1;
        m_prbs = 1'b1;
        for (int n = 0; n < 200; n++) cycle(1'b0, 1'b1, n[0], n[1]);
        prbs_sel = 1'b0;
        m_prbs = 1'b0;
        idle_cycles(30);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
